jk_seq_driver: RTL and testbench

Sequencer that drives an external bank of WIDTH JK flip-flops through a programmed state sequence. For each step it computes J/K excitation from the bank's present state and the stored target, issues a one-cycle enable, then checks the bank's fed-back state against the target. It sits upstream of the lab's JK flip-flop banks as their stimulus and self-check source.

---
 rtl/jk_seq_pkg.sv | 7 +
 rtl/jk_seq_mem.sv | 19 +
 rtl/jk_seq_driver.sv | 99 +++++++++
 tb/tb_jk_seq_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared FSM state type and JK excitation helper for the sequencer
package jk_seq_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, APPLY, CHECK, ERR} state_t;
  function automatic logic [1:0] excite(input logic q, input logic t);
    return {~q & t, q & ~t};
  endfunction
endpackage

// File: rtl/jk_seq_mem.sv
// jk_seq_mem: target-word register file, sync write and combinational read
module jk_seq_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // store a target word
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: steps a JK flop bank through stored targets and self-checks it
module jk_seq_driver
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_en,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [AW-1:0]    step
);
  state_t state;
  logic [AW:0] len_r;
  logic loop_r, stop_r;
  logic [WIDTH-1:0] cur, j_n, k_n;
  logic len_ok, last, stop_seen;
  jk_seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_en && state == IDLE),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(step),
    .rdata(cur)
  );
  for (genvar g = 0; g < WIDTH; g++) begin : g_ex
    assign {j_n[g], k_n[g]} = excite(q_fb[g], cur[g]);
  end
  assign len_ok = len != '0 && len <= (AW+1)'(DEPTH);
  assign last = {1'b0, step} == len_r - 1'b1;
  assign stop_seen = stop_r | stop;
  assign busy = state != IDLE;
  // sequencer FSM with registered excitation, enable, done and error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      j <= '0;
      k <= '0;
      jk_en <= 1'b0;
      done <= 1'b0;
      mismatch <= 1'b0;
      step <= '0;
      len_r <= '0;
      loop_r <= 1'b0;
      stop_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && stop) stop_r <= 1'b1;
      case (state)
        IDLE, ERR: if (start && len_ok) begin
          len_r <= len;
          loop_r <= loop;
          step <= '0;
          mismatch <= 1'b0;
          stop_r <= 1'b0;
          state <= DRIVE;
        end
        DRIVE: begin
          j <= j_n;
          k <= k_n;
          jk_en <= 1'b1;
          state <= APPLY;
        end
        APPLY: begin
          j <= '0;
          k <= '0;
          jk_en <= 1'b0;
          state <= CHECK;
        end
        CHECK: if (q_fb != cur) begin
          mismatch <= 1'b1;
          state <= ERR;
        end else if (last) begin
          done <= 1'b1;
          step <= (loop_r && !stop_seen) ? '0 : step;
          state <= (loop_r && !stop_seen) ? DRIVE : IDLE;
        end else begin
          step <= stop_seen ? step : step + 1'b1;
          state <= stop_seen ? IDLE : DRIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: directed checks of the JK sequencer against a behavioural JK bank
module tb_jk_seq_driver;
  import jk_seq_pkg::*;
  localparam int W = 4;
  localparam int D = 8;
  localparam int AW = 3;
  logic clk = 0, rst = 1, wr_en = 0, loop = 0, start = 0, stop = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [AW:0] len = '0;
  logic [W-1:0] q_fb, j, k;
  logic jk_en, busy, done, mismatch;
  logic [AW-1:0] step;
  logic [W-1:0] q_bank, bank_init = '0, stuck = '0;
  int tests = 0, fails = 0;
  int n_en, n_done, n_busy, busy_fall;
  logic [W-1:0] jr [32];
  logic [W-1:0] kr [32];
  logic [AW-1:0] sr [32];
  int done_at [8];
  logic [14:0] snap;

  always #5 clk = ~clk;

  // behavioural JK bank with optional stuck-at-0 bits on the feedback
  always @(posedge clk)
    if (rst) q_bank <= bank_init;
    else if (jk_en) q_bank <= (j & ~q_bank) | (~k & q_bank);
  assign q_fb = q_bank & ~stuck;

  jk_seq_driver #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop(loop), .start(start), .stop(stop), .q_fb(q_fb),
    .j(j), .k(k), .jk_en(jk_en), .busy(busy), .done(done),
    .mismatch(mismatch), .step(step)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 0;
  endtask

  // drive start at the current negedge, then observe n cycles; latencies are edges after the start edge
  task automatic go(input logic [AW:0] l, input logic lp, input int stop_at, input int n,
                    input int wr_at, input logic [W-1:0] wd, input int rst_at);
    n_en = 0; n_done = 0; n_busy = 0; busy_fall = -1; snap = '1;
    len = l; loop = lp; start = 1; wr_en = (wr_at == 0); wr_addr = '0; wr_data = wd;
    for (int c = 1; c <= n; c++) begin
      tick;
      start = 0;
      if (jk_en && n_en < 32) begin jr[n_en] = j; kr[n_en] = k; sr[n_en] = step; n_en++; end
      if (done && n_done < 8) begin done_at[n_done] = c - 1; n_done++; end
      if (busy) n_busy++; else if (busy_fall < 0) busy_fall = c - 1;
      if (c == rst_at + 1) snap = {j, k, jk_en, busy, done, mismatch, step};
      stop = (c == stop_at); wr_en = (c == wr_at); rst = (c == rst_at);
    end
    stop = 0; wr_en = 0; rst = 0;
  endtask

  task automatic test_reset;
    do_reset;
    tests++; if (j !== 4'h0) begin fails++; $display("FAIL reset_j got %h want 0", j); end
    tests++; if (k !== 4'h0) begin fails++; $display("FAIL reset_k got %h want 0", k); end
    tests++; if (jk_en !== 1'b0) begin fails++; $display("FAIL reset_jk_en got %b want 0", jk_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
    tests++; if (step !== 3'd0) begin fails++; $display("FAIL reset_step got %0d want 0", step); end
  endtask

  task automatic test_basic;
    bank_init = 4'h0; do_reset;
    wr(0, 4'h3); wr(1, 4'hA); wr(2, 4'h0);
    go(3, 0, -1, 14, -1, 0, -1);
    tests++; if (n_en !== 3) begin fails++; $display("FAIL basic_pulses got %0d want 3", n_en); end
    tests++; if ({jr[0], kr[0]} !== 8'h30) begin fails++; $display("FAIL basic_s0 got %h want 30", {jr[0], kr[0]}); end
    tests++; if ({jr[1], kr[1]} !== 8'h81) begin fails++; $display("FAIL basic_s1 got %h want 81", {jr[1], kr[1]}); end
    tests++; if ({jr[2], kr[2]} !== 8'h0A) begin fails++; $display("FAIL basic_s2 got %h want 0a", {jr[2], kr[2]}); end
    tests++; if (n_done !== 1 || done_at[0] !== 9) begin fails++; $display("FAIL basic_done got n=%0d at %0d want n=1 at 9", n_done, done_at[0]); end
    tests++; if (busy_fall !== 9) begin fails++; $display("FAIL basic_busy_fall got %0d want 9", busy_fall); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL basic_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_loop;
    do_reset;
    go(3, 1, 20, 26, -1, 0, -1);
    tests++; if (n_done !== 2) begin fails++; $display("FAIL loop_done_count got %0d want 2", n_done); end
    tests++; if (done_at[0] !== 9 || done_at[1] !== 18) begin fails++; $display("FAIL loop_done_at got %0d,%0d want 9,18", done_at[0], done_at[1]); end
    tests++; if (n_en !== 7) begin fails++; $display("FAIL loop_pulses got %0d want 7", n_en); end
    tests++; if (sr[2] !== 3'd2 || sr[3] !== 3'd0 || sr[6] !== 3'd0) begin fails++; $display("FAIL loop_wrap got %0d,%0d,%0d want 2,0,0", sr[2], sr[3], sr[6]); end
    tests++; if (busy_fall !== 21) begin fails++; $display("FAIL loop_stop_idle got %0d want 21", busy_fall); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL loop_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_fault;
    bank_init = 4'h0; stuck = 4'h4; do_reset;
    wr(0, 4'h4);
    go(1, 0, -1, 8, -1, 0, -1);
    tests++; if (jr[0] !== 4'h4) begin fails++; $display("FAIL fault_j got %h want 4", jr[0]); end
    tests++; if (mismatch !== 1'b1) begin fails++; $display("FAIL fault_mismatch got %b want 1", mismatch); end
    tests++; if (dut.state !== ERR || busy !== 1'b1) begin fails++; $display("FAIL fault_err got %0d busy %b want ERR busy 1", dut.state, busy); end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL fault_no_done got %0d want 0", n_done); end
    stuck = 4'h0;
    go(1, 0, -1, 6, -1, 0, -1);
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL fault_restart_mismatch got %b want 0", mismatch); end
    tests++; if (n_done !== 1 || done_at[0] !== 3) begin fails++; $display("FAIL fault_restart_done got n=%0d at %0d want n=1 at 3", n_done, done_at[0]); end
  endtask

  task automatic test_hold;
    bank_init = 4'h5; do_reset;
    wr(0, 4'h5);
    go(1, 0, -1, 6, -1, 0, -1);
    tests++; if (n_en !== 1) begin fails++; $display("FAIL hold_pulses got %0d want 1", n_en); end
    tests++; if ({jr[0], kr[0]} !== 8'h00) begin fails++; $display("FAIL hold_jk got %h want 00", {jr[0], kr[0]}); end
    tests++; if (done_at[0] !== 3 || mismatch !== 1'b0) begin fails++; $display("FAIL hold_done got at %0d mm %b want at 3 mm 0", done_at[0], mismatch); end
  endtask

  task automatic test_bad_len;
    go(0, 0, -1, 4, -1, 0, -1);
    tests++; if (n_busy !== 0) begin fails++; $display("FAIL len0_busy got %0d cycles want 0", n_busy); end
    go(9, 0, -1, 4, -1, 0, -1);
    tests++; if (n_busy !== 0) begin fails++; $display("FAIL len9_busy got %0d cycles want 0", n_busy); end
  endtask

  task automatic test_full_len;
    bank_init = 4'h0; do_reset;
    for (int i = 0; i < 7; i++) wr(AW'(i), W'(i + 1));
    wr(7, 4'hF);
    go(8, 0, -1, 28, -1, 0, -1);
    tests++; if (n_done !== 1 || done_at[0] !== 24) begin fails++; $display("FAIL full_done got n=%0d at %0d want n=1 at 24", n_done, done_at[0]); end
    tests++; if (n_en !== 8) begin fails++; $display("FAIL full_pulses got %0d want 8", n_en); end
    tests++; if ({jr[3], kr[3]} !== 8'h43) begin fails++; $display("FAIL full_s3 got %h want 43", {jr[3], kr[3]}); end
    tests++; if ({jr[7], kr[7]} !== 8'h80) begin fails++; $display("FAIL full_s7 got %h want 80", {jr[7], kr[7]}); end
    tests++; if (mismatch !== 1'b0) begin fails++; $display("FAIL full_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_wr_busy;
    bank_init = 4'h0; do_reset;
    go(1, 0, -1, 6, 1, 4'hE, -1);
    tests++; if ({jr[0], kr[0]} !== 8'h10) begin fails++; $display("FAIL wrbusy_first got %h want 10", {jr[0], kr[0]}); end
    go(1, 0, -1, 6, -1, 0, -1);
    tests++; if ({jr[0], kr[0]} !== 8'h00) begin fails++; $display("FAIL wrbusy_mem got %h want 00", {jr[0], kr[0]}); end
  endtask

  task automatic test_wr_start;
    bank_init = 4'h0; do_reset;
    go(1, 0, -1, 6, 0, 4'h6, -1);
    tests++; if ({jr[0], kr[0]} !== 8'h60) begin fails++; $display("FAIL wrstart_jk got %h want 60", {jr[0], kr[0]}); end
    tests++; if (done_at[0] !== 3 || mismatch !== 1'b0) begin fails++; $display("FAIL wrstart_done got at %0d mm %b want at 3 mm 0", done_at[0], mismatch); end
  endtask

  task automatic test_rst_mid;
    bank_init = 4'h0; do_reset;
    wr(0, 4'h3); wr(1, 4'hA); wr(2, 4'h0);
    go(3, 0, -1, 12, -1, 0, 5);
    tests++; if (n_en !== 2 || sr[1] !== 3'd1) begin fails++; $display("FAIL rst_apply got pulses %0d step %0d want 2 step 1", n_en, sr[1]); end
    tests++; if (snap !== 15'd0) begin fails++; $display("FAIL rst_outputs got %h want 0000", snap); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL rst_state got %0d want IDLE", dut.state); end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL rst_no_done got %0d want 0", n_done); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_loop;
    test_fault;
    test_hold;
    test_bad_len;
    test_full_len;
    test_wr_busy;
    test_wr_start;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
